// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_TIMEOUT    = 1500000,
    parameter int PKT_TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg
);
    // Handshake: a byte moves when cmd_valid && cmd_ready in the same clk;
    // cmd_ready is high only while idle, so no command is ever queued.

    localparam int CNT_MAX0 = (RTS_TIMEOUT > PKT_TIMEOUT) ? RTS_TIMEOUT : PKT_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > INHIBIT_CYCLES) ? CNT_MAX0 : INHIBIT_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_TIMEOUT - 1);
    localparam logic [CW-1:0] PKT_LAST = CW'(PKT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_IDLE, S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity, parity_n;
    logic          tx_oe, tx_oe_n;
    logic          done_q, done_n;
    logic [1:0]    code_q, code_n;
    logic          fall, clk_s, data_s;

    // Sync flops reset high (idle bus) so releasing reset never fakes an edge.
    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            tx_oe     <= 1'b0;
            done_q    <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state     <= state_n;
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            parity    <= parity_n;
            tx_oe     <= tx_oe_n;
            done_q    <= done_n;
            code_q    <= code_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        parity_n  = parity;
        tx_oe_n   = tx_oe;
        done_n    = 1'b0;
        code_n    = code_q;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (cmd_valid && cmd_ready) begin
                    shreg_n  = cmd_data;
                    parity_n = ~^cmd_data;
                    code_n   = 2'b00;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    state_n = S_RTS;
                end
            end
            S_RTS: begin
                if (cnt == RTS_LAST) begin
                    code_n  = 2'b01;
                    state_n = S_FAIL;
                end else if (fall) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    tx_oe_n   = 1'b1;
                    state_n   = S_SEND;
                end
            end
            S_SEND: begin
                // Timeout wins over an edge arriving in the same clk.
                if (cnt == PKT_LAST) begin
                    code_n  = 2'b10;
                    state_n = S_FAIL;
                end else if (fall) begin
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx < 4'd8) begin
                        tx_oe_n = ~shreg[bit_idx[2:0]];
                    end else if (bit_idx == 4'd8) begin
                        tx_oe_n = ~parity;
                    end else if (bit_idx == 4'd9) begin
                        tx_oe_n = 1'b0;
                    end else if (!data_s) begin
                        cnt_n   = '0;
                        state_n = S_WAIT_IDLE;
                    end else begin
                        code_n  = 2'b11;
                        state_n = S_FAIL;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (cnt == PKT_LAST) begin
                    code_n  = 2'b10;
                    state_n = S_FAIL;
                end else if (clk_s && data_s) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_FAIL: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign ps2_clk_oe  = (state == S_INHIBIT);
    assign ps2_data_oe = (state == S_RTS) || ((state == S_SEND) && tx_oe);
    assign busy        = (state == S_INHIBIT) || (state == S_RTS) ||
                         (state == S_SEND) || (state == S_WAIT_IDLE);
    assign err         = (state == S_FAIL);
    assign done        = done_q;
    assign err_code    = code_q;
    assign cmd_ready   = (state == S_IDLE) && !done_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// and an outcome model predicts done/err and the bit stream per command.
module tb_ps2_host_tx;
    localparam int INH  = 200;
    localparam int RTS  = 2000;
    localparam int PKT  = 1500;
    localparam int HALF = 20;
    localparam int QTR  = 5;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_STOP5  = 2;
    localparam int M_NOCLK  = 3;
    localparam int M_RESET  = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic [2:0] state_dbg;
    logic       dev_clk, dev_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         pulse_cnt = 0;
    int         rts_start = 0;
    int         fall0_cyc = 0;
    int         inh_run   = 0;
    logic       prev_pulse = 1'b0;
    logic [1:0] model_code = 2'b00;
    logic [2:0] exp_q[$];
    logic [10:0] fr;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_TIMEOUT(RTS), .PKT_TIMEOUT(PKT)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [2:0] expected_outcome(input int mode);
        case (mode)
            M_NORMAL: return 3'b100;
            M_NOACK:  return 3'b011;
            M_STOP5:  return 3'b010;
            default:  return 3'b001;
        endcase
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        int d;
        if (!rstn) begin
            prev_pulse = 1'b0;
            inh_run    = 0;
        end else begin
            if (done || err) begin
                pulse_cnt++;
                check("done_err_exclusive", {31'd0, done && err}, 0);
                check("pulse_busy_low", {31'd0, busy}, 0);
                check("pulse_ready_low", {31'd0, cmd_ready}, 0);
                check("pulse_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome", {29'd0, done, err_code}, {29'd0, e});
                    if (!e[2] && e[1:0] == 2'b01)
                        check("rts_timeout_len", cyc - rts_start, RTS);
                    if (!e[2] && e[1:0] == 2'b10) begin
                        d = cyc - fall0_cyc;
                        check("pkt_timeout_window", {31'd0, (d >= PKT + 2) && (d <= PKT + 4)}, 1);
                    end
                    model_code = e[2] ? 2'b00 : e[1:0];
                end
            end else if (!busy) begin
                check("err_code_hold", {30'd0, err_code}, {30'd0, model_code});
                if (prev_pulse) check("ready_after_pulse", {31'd0, cmd_ready}, 1);
            end
            if (busy) check("ready_low_while_busy", {31'd0, cmd_ready}, 0);
            if (ps2_clk_oe) begin
                inh_run++;
            end else if (inh_run != 0) begin
                check("inhibit_len", inh_run, INH);
                check("rts_data_oe_with_clk_release", {31'd0, ps2_data_oe}, 1);
                rts_start = cyc;
                inh_run   = 0;
            end
            prev_pulse = done || err;
        end
    end

    // ---------------- driver + device model ----------------
    task automatic run_txn(input logic [7:0] d, input int mode, output logic [10:0] frame);
        int  p0;
        bit  ok;
        frame = '1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept", {31'd0, ok}, 1);
        if (!ok) begin cmd_valid = 1'b0; return; end
        p0 = pulse_cnt;
        if (mode != M_RESET) exp_q.push_back(expected_outcome(mode));
        @(posedge clk);
        model_code = 2'b00;
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            cmd_data = 8'($urandom_range(0, 255));
            repeat (20) @(negedge clk);
        end
        cmd_valid = 1'b0;

        if (mode != M_NOCLK) begin
            ok = 1'b0;
            for (int i = 0; i < INH + 50; i++) begin
                if (!ps2_clk_oe && ps2_data_oe) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check("rts_seen", {31'd0, ok}, 1);
            repeat (4) @(negedge clk);
            for (int k = 0; k < 12; k++) begin
                if (k == 11 && mode == M_NORMAL) dev_data = 1'b0;
                repeat (QTR) @(negedge clk);
                dev_clk = 1'b0;
                if (k == 0) fall0_cyc = cyc;
                repeat (HALF) @(negedge clk);
                if (mode == M_RESET && k == 4) begin
                    rstn = 1'b0;
                    #1;
                    check("reset_releases_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                    check("reset_busy_low", {31'd0, busy}, 0);
                    check("reset_no_pulse", {30'd0, done, err}, 0);
                    dev_clk = 1'b1;
                    break;
                end
                dev_clk = 1'b1;
                if (k < 11) frame[k] = ps2_data_in;
                repeat (HALF) @(negedge clk);
                if (mode == M_STOP5 && k == 5) break;
            end
            dev_data = 1'b1;
        end

        if (mode == M_RESET) begin
            repeat (3) @(negedge clk);
            model_code = 2'b00;
            rstn = 1'b1;
            repeat (40) @(negedge clk);
            check("no_pulse_after_reset", pulse_cnt, p0);
            check("ready_after_reset", {31'd0, cmd_ready}, 1);
        end else begin
            ok = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (pulse_cnt != p0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check("outcome_seen", {31'd0, ok}, 1);
            if (mode == M_NORMAL || mode == M_NOACK)
                check("frame", {21'd0, frame}, {21'd0, model_frame(d)});
        end
        repeat ($urandom_range(2, 20)) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int mode;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        dev_clk   = 1'b1;
        dev_data  = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, cmd_ready}, 1);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_pulses", {30'd0, done, err}, 0);
        check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("reset_err_code", {30'd0, err_code}, 0);

        run_txn(8'hED, M_NORMAL, fr);
        check("ed_frame_literal", {21'd0, fr}, 32'h7DA);
        run_txn(8'hF4, M_NORMAL, fr);
        check("f4_parity_literal", {31'd0, fr[9]}, 0);
        run_txn(8'hFF, M_NORMAL, fr);
        check("ff_parity_literal", {31'd0, fr[9]}, 1);
        run_txn(8'h3C, M_NOCLK, fr);
        check("rts_err_code_literal", {30'd0, err_code}, 1);
        run_txn(8'hF3, M_NOACK, fr);
        check("noack_err_code_literal", {30'd0, err_code}, 3);
        run_txn(8'hED, M_STOP5, fr);
        check("pkt_err_code_literal", {30'd0, err_code}, 2);
        run_txn(8'h55, M_RESET, fr);

        for (int t = 0; t < 10; t++) begin
            r = $urandom_range(0, 9);
            mode = (r < 6) ? M_NORMAL : (r == 6) ? M_NOACK : (r == 7) ? M_STOP5 :
                   (r == 8) ? M_NOCLK : M_RESET;
            run_txn(8'($urandom_range(0, 255)), mode, fr);
        end

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
